ula_sequenciador: RTL and testbench

- Upstream controller for the 8-bit ULA (ALU). Accepts one instruction at a time over a valid/ready handshake.
- Holds a 4x8 register file. Drives the ULA operands and opcode, waits out the ULA's registered latency, then writes the result and carry/borrow flag back.
- Turns the bare ULA datapath into a serialized, instruction-driven execution unit.

---
 rtl/ula_sequenciador.sv | 174 +++++++++++++++++
 tb/tb_ula_sequenciador.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// ---------------------------------------------------------------------------
// ula_sequenciador
//
// Upstream controller for the 8-bit ULA (ALU). Accepts one 16-bit instruction
// at a time over a valid/ready handshake. It holds a 4x8 register file. For an
// ALU instruction it drives registered operands and an opcode into the ULA,
// waits out the ULA pipeline latency, and then writes the result and the
// carry/borrow flag back. An immediate load writes the register file directly.
//
// Instruction word:
//   [15:13] op   ULA opcode (110/111 are illegal)
//   [12]    ld   1 = immediate load R[rd] <= imm
//   [11:10] rd   destination register
//   [9:8]   ra   operand A register
//   [7:6]   rb   operand B register
//   [7:0]   imm  immediate value (only used when ld = 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (wins over everything)
//   instr        instruction word, see above
//   instr_valid  instr is valid this cycle
//   instr_ready  sequencer can accept instr (high only in IDLE)
//   ula_a/ula_b  registered operands to the ULA
//   ula_op       registered opcode to the ULA
//   ula_s        ULA result
//   ula_flag     ULA carry/borrow flag
//   carry        last captured ULA flag
//   done         one-cycle pulse when an instruction retires
//   illegal      one-cycle pulse when opcode 110/111 is accepted
//   dbg_sel      register file read index
//   dbg_data     combinational read of R[dbg_sel]
//   zero         (only with ULA_SEQ_ZERO_EN) result/immediate was zero
//
// Optional build macro: ULA_SEQ_ZERO_EN adds the zero output.
// ---------------------------------------------------------------------------
module ula_sequenciador #(
  parameter int ULA_LAT = 2,
  parameter int NREG    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  ula_a,
  output logic [7:0]  ula_b,
  output logic [2:0]  ula_op,
  input  logic [7:0]  ula_s,
  input  logic        ula_flag,
  output logic        carry,
  output logic        done,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
`ifdef ULA_SEQ_ZERO_EN
  ,
  output logic        zero
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam int CNT_W = (ULA_LAT < 1) ? 1 : $clog2(ULA_LAT + 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       rd_r;
  logic [7:0]       regs_r [NREG];

  // Instruction field decode
  logic [2:0] op_s;
  logic       ld_s;
  logic [1:0] rd_s;
  logic [1:0] ra_s;
  logic [1:0] rb_s;
  logic [7:0] imm_s;
  logic       hs_s;
  logic       op_illegal_s;

  assign op_s         = instr[15:13];
  assign ld_s         = instr[12];
  assign rd_s         = instr[11:10];
  assign ra_s         = instr[9:8];
  assign rb_s         = instr[7:6];
  assign imm_s        = instr[7:0];
  assign op_illegal_s = (op_s[2:1] == 2'b11);

  // Only IDLE accepts work; the state register keeps this output glitch-free
  assign instr_ready = (state_r == IDLE);
  assign hs_s        = instr_valid & instr_ready;

  // Debug port reads the register file directly, so a write is visible the
  // cycle after its edge
  assign dbg_data = regs_r[dbg_sel];

  // Sequencer FSM, register file, ULA drive and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      rd_r    <= 2'b00;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 8'h00;
      end
      ula_a   <= 8'h00;
      ula_b   <= 8'h00;
      ula_op  <= 3'b000;
      carry   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
`ifdef ULA_SEQ_ZERO_EN
      zero    <= 1'b0;
`endif
    end else begin
      // Pulses default low; a branch below raises them for one cycle
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            if (ld_s) begin
              regs_r[rd_s] <= imm_s;
              done         <= 1'b1;
`ifdef ULA_SEQ_ZERO_EN
              zero         <= (imm_s == 8'h00);
`endif
              state_r      <= IDLE;
            end else if (op_illegal_s) begin
              // Rejected opcode: nothing issued, nothing written, carry kept
              illegal <= 1'b1;
              done    <= 1'b1;
              state_r <= IDLE;
            end else begin
              // Operands are sampled here, so rd == ra/rb uses the old value
              ula_a   <= regs_r[ra_s];
              ula_b   <= regs_r[rb_s];
              ula_op  <= op_s;
              rd_r    <= rd_s;
              cnt_r   <= CNT_W'(ULA_LAT);
              state_r <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // ula_a/b/op are held untouched here: the ULA flag is combinational
          // on the opcode. A full ULA_LAT wait means stale pipeline data from
          // an aborted instruction can never be captured.
          if (cnt_r == {CNT_W{1'b0}}) begin
            regs_r[rd_r] <= ula_s;
            carry        <= ula_flag;
            done         <= 1'b1;
`ifdef ULA_SEQ_ZERO_EN
            zero         <= (ula_s == 8'h00);
`endif
            state_r      <= IDLE;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
            state_r <= EXEC;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// ---------------------------------------------------------------------------
// Testbench for ula_sequenciador. A behavioural ULA (input register plus
// output register, opcodes 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
// 101 NOT a) sits behind the sequencer. A transaction-level model tracks the
// register file, carry and zero from the instruction semantics alone.
// ---------------------------------------------------------------------------
module tb_ula_sequenciador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  ula_a, ula_b;
  logic [2:0]  ula_op;
  logic [7:0]  ula_s;
  logic        ula_flag;
  logic        carry, done, illegal;
  logic [1:0]  dbg_sel = 2'b00;
  logic [7:0]  dbg_data;
`ifdef ULA_SEQ_ZERO_EN
  logic        zero;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  // Reference model state
  logic [7:0] m_regs [4];
  logic       m_carry;
  logic       m_zero;

  ula_sequenciador dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_flag(ula_flag), .carry(carry), .done(done),
    .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef ULA_SEQ_ZERO_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  // 9-bit result: bit 8 is carry for ADD and borrow for SUB, 0 otherwise
  function automatic logic [8:0] alu9(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      default: return 9'd0;
    endcase
  endfunction

  // Behavioural ULA: two registered stages, flag gated by the live opcode
  logic [7:0] ua_q, ub_q;
  logic [2:0] uo_q;
  logic [8:0] ur_q;
  always @(posedge clk) begin
    ua_q <= ula_a;
    ub_q <= ula_b;
    uo_q <= ula_op;
    ur_q <= alu9(uo_q, ua_q, ub_q);
  end
  assign ula_s    = ur_q[7:0];
  assign ula_flag = ur_q[8] & (ula_op[2:1] == 2'b00);

  // Event monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
    return {op, 1'b0, rd, ra, rb, 6'b000000};
  endfunction

  function automatic logic [15:0] mk_ld(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b000, 1'b1, rd, 2'b00, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_carry = 1'b0;
    m_zero  = 1'b0;
  endtask

  // Apply one instruction's architectural effect to the model
  task automatic model_exec(input logic [15:0] ins);
    logic [8:0] r;
    if (ins[12]) begin
      m_regs[ins[11:10]] = ins[7:0];
      m_zero = (ins[7:0] == 8'h00);
    end else if (ins[15:14] != 2'b11) begin
      r = alu9(ins[15:13], m_regs[ins[9:8]], m_regs[ins[7:6]]);
      m_regs[ins[11:10]] = r[7:0];
      m_carry = r[8];
      m_zero = (r[7:0] == 8'h00);
    end
  endtask

  // Compare the whole architectural state against the model
  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0];
      #1;
      chk($sformatf("%s_R%0d", tag, i), {24'd0, dbg_data}, {24'd0, m_regs[i]});
    end
    chk({tag, "_carry"}, {31'd0, carry}, {31'd0, m_carry});
`ifdef ULA_SEQ_ZERO_EN
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, m_zero});
`endif
  endtask

  // Issue one instruction, check timing/pulses, then the resulting state
  task automatic exec_check(input logic [15:0] ins, input string tag);
    int  k, lat, rdy_low;
    bit  is_alu, ill_exp;
    logic ill_seen;
    is_alu  = !ins[12] && (ins[15:14] != 2'b11);
    ill_exp = !ins[12] && (ins[15:14] == 2'b11);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (!done && lat < 20) begin
      if (!instr_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    ill_seen = illegal;
    model_exec(ins);
    chk({tag, "_latency"}, lat, is_alu ? 32'd4 : 32'd1);
    chk({tag, "_ready_low"}, rdy_low, is_alu ? 32'd3 : 32'd0);
    chk({tag, "_illegal"}, {31'd0, ill_seen}, {31'd0, ill_exp});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, illegal}, 32'd0);
    check_state(tag);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  exp_val;
    logic        exp_carry;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int h0, d0, e0, e1, k;
    logic [15:0] r_ins;

    tbl[0]  = '{mk_ld(2'd0, 8'hF0),               8'hF0, 1'b0};
    tbl[1]  = '{mk_ld(2'd1, 8'h20),               8'h20, 1'b0};
    tbl[2]  = '{mk_alu(3'd0, 2'd2, 2'd0, 2'd1),   8'h10, 1'b1};
    tbl[3]  = '{mk_ld(2'd0, 8'h05),               8'h05, 1'b1};
    tbl[4]  = '{mk_ld(2'd1, 8'h07),               8'h07, 1'b1};
    tbl[5]  = '{mk_alu(3'd1, 2'd3, 2'd0, 2'd1),   8'hFE, 1'b1};
    tbl[6]  = '{mk_alu(3'd7, 2'd0, 2'd0, 2'd0),   8'h05, 1'b1};
    tbl[7]  = '{mk_alu(3'd2, 2'd0, 2'd3, 2'd2),   8'h10, 1'b0};
    tbl[8]  = '{mk_alu(3'd4, 2'd1, 2'd1, 2'd1),   8'h00, 1'b0};
    tbl[9]  = '{mk_alu(3'd5, 2'd2, 2'd2, 2'd0),   8'hEF, 1'b0};
    tbl[10] = '{mk_alu(3'd6, 2'd3, 2'd0, 2'd0),   8'hFE, 1'b0};
    tbl[11] = '{mk_alu(3'd0, 2'd3, 2'd3, 2'd3),   8'hFC, 1'b1};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_ula_op", {29'd0, ula_op}, 32'd0);
    chk("rst_ula_ab", {16'd0, ula_a, ula_b}, 32'd0);
    chk("rst_pulses", {30'd0, done, illegal}, 32'd0);
    check_state("rst");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      exec_check(tbl[i].ins, $sformatf("vec%0d", i));
      @(negedge clk);
      dbg_sel = tbl[i].ins[11:10];
      #1;
      chk($sformatf("vec%0d_val", i), {24'd0, dbg_data}, {24'd0, tbl[i].exp_val});
      chk($sformatf("vec%0d_cy", i), {31'd0, carry}, {31'd0, tbl[i].exp_carry});
    end

    // Back-to-back loads at one per cycle
    @(negedge clk);
    h0 = hs_cnt;
    d0 = done_cnt;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = mk_ld(i[1:0], 8'hA0 + 8'(i));
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'hA0 + 8'(i);
    m_zero = 1'b0;
    chk("b2b_handshakes", hs_cnt - h0, 32'd4);
    repeat (2) @(negedge clk);
    chk("b2b_dones", done_cnt - d0, 32'd4);
    check_state("b2b");

    // Reset one cycle after an ADD handshake: aborted, no writeback
    exec_check(mk_ld(2'd0, 8'h11), "pre_rst0");
    exec_check(mk_ld(2'd1, 8'h22), "pre_rst1");
    @(negedge clk);
    instr = mk_alu(3'd0, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_ula_op", {29'd0, ula_op}, 32'd0);
    chk("abort_ula_ab", {16'd0, ula_a, ula_b}, 32'd0);
    check_state("abort");
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    check_state("abort_late");

    // Held request: second op waits for the first IDLE edge
    exec_check(mk_ld(2'd0, 8'h5A), "held_ld0");
    exec_check(mk_ld(2'd1, 8'h0F), "held_ld1");
    @(negedge clk);
    h0 = hs_cnt;
    d0 = done_cnt;
    instr = mk_alu(3'd4, 2'd0, 2'd0, 2'd1);
    instr_valid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (hs_cnt == h0 && k < 20);
    e0 = cyc;
    instr = mk_alu(3'd5, 2'd0, 2'd0, 2'd0);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (hs_cnt == h0 + 1 && k < 20);
    e1 = cyc;
    instr_valid = 1'b0;
    chk("held_spacing", e1 - e0, 32'd4);
    k = 0;
    while (done_cnt - d0 < 2 && k < 20) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("held_dones", done_cnt - d0, 32'd2);
    chk("held_handshakes", hs_cnt - h0, 32'd2);
    model_exec(mk_alu(3'd4, 2'd0, 2'd0, 2'd1));
    model_exec(mk_alu(3'd5, 2'd0, 2'd0, 2'd0));
    dbg_sel = 2'd0;
    #1;
    chk("held_R0_AA", {24'd0, dbg_data}, 32'h0000_00AA);
    check_state("held");

`ifdef ULA_SEQ_ZERO_EN
    exec_check(mk_ld(2'd0, 8'h3C), "z_ld");
    exec_check(mk_alu(3'd4, 2'd1, 2'd0, 2'd0), "z_xor");
    chk("z_set", {31'd0, zero}, 32'd1);
    exec_check(mk_ld(2'd2, 8'h01), "z_ld1");
    chk("z_clr", {31'd0, zero}, 32'd0);
`endif

    // Randomized instructions against the model
    for (int i = 0; i < 40; i++) begin
      r_ins = 16'($urandom);
      exec_check(r_ins, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
